// File: rtl/rf_scoreboard.sv
// Register file with two combinational read ports, one clocked write port and a per-register busy scoreboard.
// Optional macro RF_BYPASS_EN forwards same-cycle write data and post-edge busy state to the read ports.
module rf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              SetBusy,
  input  logic [ADDR_W-1:0] SetBusyAddr,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  output logic              BusyAny
);

  localparam int   DEPTH  = 2**ADDR_W;
  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic              writeEn;
  logic              read1Zero;
  logic              read2Zero;

  assign writeEn   = RegWrite && !(ZERO_EN && (WriteAddr == '0));
  assign read1Zero = ZERO_EN && (ReadAddr1 == '0);
  assign read2Zero = ZERO_EN && (ReadAddr2 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[WriteAddr] <= WriteData;
    end
  end

  // Set is applied after clear so a newly issued producer wins over a retiring one.
  always_comb begin
    busyNext = busy;
    if (RegWrite) begin
      busyNext[WriteAddr] = 1'b0;
    end
    if (SetBusy) begin
      busyNext[SetBusyAddr] = 1'b1;
    end
    if (ZERO_EN) begin
      busyNext[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  assign BusyAny = |busy;

  always_comb begin
    ReadData1 = regs[ReadAddr1];
    ReadData2 = regs[ReadAddr2];
    Busy1     = busy[ReadAddr1];
    Busy2     = busy[ReadAddr2];
`ifdef RF_BYPASS_EN
    // Gated by rst_n so the read ports stay at zero for the whole reset window.
    if (rst_n && RegWrite && (ReadAddr1 == WriteAddr)) begin
      ReadData1 = WriteData;
      Busy1     = SetBusy && (SetBusyAddr == ReadAddr1);
    end
    if (rst_n && RegWrite && (ReadAddr2 == WriteAddr)) begin
      ReadData2 = WriteData;
      Busy2     = SetBusy && (SetBusyAddr == ReadAddr2);
    end
`endif
    if (read1Zero) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end
    if (read2Zero) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard bench for rf_scoreboard: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_rf_scoreboard;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        SetBusy;
  logic [4:0]  SetBusyAddr;
  logic [4:0]  ReadAddr1;
  logic [4:0]  ReadAddr2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Busy1;
  logic        Busy2;
  logic        BusyAny;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        bAny;
  } exp_t;

  exp_t expQ[$];
  logic sampleValid;
  int   checks;
  int   failures;

  rf_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWrite    (RegWrite),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .SetBusy     (SetBusy),
    .SetBusyAddr (SetBusyAddr),
    .ReadAddr1   (ReadAddr1),
    .ReadAddr2   (ReadAddr2),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .Busy1       (Busy1),
    .Busy2       (Busy2),
    .BusyAny     (BusyAny)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", nm, field, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL monitor_underflow actual=empty required=entry");
    end else begin
      e = expQ.pop_front();
      cmp(e.name, "ReadData1", ReadData1, e.rd1);
      cmp(e.name, "ReadData2", ReadData2, e.rd2);
      cmp(e.name, "Busy1", {31'd0, Busy1}, {31'd0, e.b1});
      cmp(e.name, "Busy2", {31'd0, Busy2}, {31'd0, e.b2});
      cmp(e.name, "BusyAny", {31'd0, BusyAny}, {31'd0, e.bAny});
    end
  endtask

  always @(negedge clk) begin
    if (sampleValid) begin
      checkOutput();
    end
  end

  // Drives one cycle of inputs just after the rising edge; they are consumed at the next rising edge.
  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic sb, input logic [4:0] sba,
                               input logic [4:0] ra1, input logic [4:0] ra2);
    @(posedge clk);
    #1;
    rst_n       = rst;
    RegWrite    = we;
    WriteAddr   = wa;
    WriteData   = wd;
    SetBusy     = sb;
    SetBusyAddr = sba;
    ReadAddr1   = ra1;
    ReadAddr2   = ra2;
    sampleValid = 1'b0;
  endtask

  task automatic expectOut(input string nm, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic b1, input logic b2, input logic bAny);
    exp_t e;
    e.name = nm;
    e.rd1  = rd1;
    e.rd2  = rd2;
    e.b1   = b1;
    e.b2   = b2;
    e.bAny = bAny;
    expQ.push_back(e);
    sampleValid = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    sampleValid = 1'b0;
    rst_n       = 1'b0;
    RegWrite    = 1'b0;
    WriteAddr   = '0;
    WriteData   = '0;
    SetBusy     = 1'b0;
    SetBusyAddr = '0;
    ReadAddr1   = '0;
    ReadAddr2   = '0;
    repeat (2) @(posedge clk);

    applyStimulus(1'b0, 1'b1, 5'd3, 32'h0000_0077, 1'b1, 5'd4, 5'd3, 5'd4);
    expectOut("in_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    expectOut("reset_discard", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd31);
    expectOut("wr_r5", BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 5'd31, 32'h1234_5678, 1'b0, 5'd0, 5'd5, 5'd31);
    expectOut("wr_r31", 32'hDEAD_BEEF, BYP ? 32'h1234_5678 : 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31);
    expectOut("rd_r5_r31", 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    expectOut("wr_r0", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5);
    expectOut("rd_r0_after", 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5);
    expectOut("set_r7", 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 5'd7, 32'h0000_00A5, 1'b0, 5'd0, 5'd7, 5'd7);
    expectOut("clr_r7", BYP ? 32'hA5 : 32'h0, BYP ? 32'hA5 : 32'h0, !BYP, !BYP, 1'b1);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    expectOut("rd_r7", 32'hA5, 32'hA5, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 5'd7, 32'h0000_005A, 1'b1, 5'd7, 5'd7, 5'd5);
    expectOut("set_clr_r7", BYP ? 32'h5A : 32'hA5, 32'hDEAD_BEEF, BYP, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    expectOut("set_wins", 32'h5A, 32'h5A, 1'b1, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 5'd0, 5'd9, 5'd7);
    expectOut("bypass_r9", BYP ? 32'h55 : 32'h0, 32'h5A, 1'b0, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b1, 5'd7, 32'h0000_0066, 1'b0, 5'd0, 5'd9, 5'd9);
    expectOut("rd_r9_next", 32'h55, 32'h55, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7, 5'd9);
    expectOut("rd_r7_r9", 32'h66, 32'h55, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd31);
    expectOut("busy_r3", 32'h0, 32'h1234_5678, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b1, 5'd5, 32'h0000_0099, 1'b1, 5'd6, 5'd5, 5'd31);
    expectOut("midrun_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    expectOut("post_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd31);
    expectOut("post_reset_clear", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    sampleValid = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue_drain actual=%0d required=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
